sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Switch-conditioning stage between the DE0 board slide switches and the Qsys switch PIO input port (in_port).
- Synchronises each raw, asynchronous switch line into clk.
- Debounces each line with a per-bit stability counter.
- Provides one-cycle rise/fall event pulses for local logic that must not poll the PIO.

Parameters:
- WIDTH, 4, number of switch lines; matches PIO in_port width.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range >= 1.
- CNT_W, clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_clean  output  WIDTH  debounced level; drives PIO in_port.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_clean goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_clean goes 1->0.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0, all registers clear: sync1, sync2, cnt, sw_clean, sw_rise and sw_fall all read 0.
- Synchroniser:
  - Two flops per bit: sync1 <= sw_raw, sync2 <= sync1.
  - No logic between the two flops.
  - Only sync2 feeds downstream logic.
- Per-bit counter, evaluated at each clk edge:
  - If sync2 == sw_clean: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: sw_clean <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Glitch rejection: any single cycle with sync2 == sw_clean restarts the count from 0. Acceptance requires DEBOUNCE_CYCLES consecutive mismatching cycles.
- Latency:
  - Take a raw level first sampled by sync1 at edge E0 and held stable thereafter.
  - sw_clean updates at edge E(DEBOUNCE_CYCLES+1).
  - With DEBOUNCE_CYCLES=1, sw_clean lags sw_raw by exactly 2 edges after E0.
- Events:
  - sw_rise[i] and sw_fall[i] are registered and assert in the same cycle that sw_clean[i] changes.
  - Each pulse lasts exactly one cycle; both are 0 otherwise.
  - sw_rise[i] and sw_fall[i] are never both 1.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses on those bits.
- Counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
- Reset mid-count: the count is discarded.
- Switch held high through reset release: sw_clean starts at 0 and the switch is accepted as a normal 0->1 change. One sw_rise pulse occurs DEBOUNCE_CYCLES+2 edges after reset release. This is intended behaviour.
- No combinational path from sw_raw to any output.

Decomposition:
- Shared package sw_pkg:
  - SW_WIDTH = 4.
  - DEBOUNCE_10MS_50MHZ = 500000.
  - clog2 function used for CNT_W.
- One sub-module, sw_debounce_bit:
  - Contains the synchroniser, counter, level register and edge pulses for a single line.
  - Has parameters DEBOUNCE_CYCLES and CNT_W.
  - The top level instantiates it WIDTH times in a generate loop.
  - The top level contains no other logic.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=8):
- Reset with sw_raw=0000, release, hold 20 cycles -> sw_clean=0000; sw_rise=0000 and sw_fall=0000 throughout.
- sw_raw 0000->0001, held -> sw_clean[0]=1 exactly 9 edges after the first sampling edge; sw_rise=0001 for exactly that one cycle.
- sw_raw[1] pulses high for 7 cycles, then returns low -> sw_clean stays 0000; no pulses. Then hold high for 8+ cycles -> accepted.
- Bounce: sw_raw[2] toggles 1,0,1,1,0 at 3-cycle intervals, then holds 1 -> exactly one sw_rise[2] pulse, 9 edges after the final 0->1 sample.
- sw_raw 0000->1111 in one cycle, later 1111->0101 -> sw_rise=1111 on one cycle; later sw_fall=1010 on one cycle; sw_clean ends at 0101.
- Assert reset_n=0 at cnt=5 with sw_raw=1000 held, then release -> all outputs 0 during reset; one sw_rise[3] pulse 10 edges after release.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants and helpers for the switch conditioning stage
package sw_pkg;

    localparam int SW_WIDTH            = 4;
    localparam int DEBOUNCE_10MS_50MHZ = 500000;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch line: 2-flop synchroniser, stability counter, level and edge pulses
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw_i,
    output logic sw_clean_o,
    output logic sw_rise_o,
    output logic sw_fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            clean_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sw_raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_clean_o = clean_q;
    assign sw_rise_o  = rise_q;
    assign sw_fall_o  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounced switch bank feeding the PIO in_port, with rise/fall event pulses
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .sw_raw_i  (sw_raw[i]),
            .sw_clean_o(sw_clean[i]),
            .sw_rise_o (sw_rise[i]),
            .sw_fall_o (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce (WIDTH=4, DEBOUNCE_CYCLES=8)
module tb_sw_debounce;

    logic       clk;
    logic       reset_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_clean;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;

    int n_cmp;
    int n_err;

    sw_debounce #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0;
        sw_raw  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({sw_clean, sw_rise, sw_fall} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_hold: got clean=%b rise=%b fall=%b, want all 0", sw_clean, sw_rise, sw_fall);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({sw_clean, sw_rise, sw_fall} !== 12'h000) begin
                n_err++;
                $display("FAIL reset_idle k=%0d: got clean=%b rise=%b fall=%b, want all 0", k, sw_clean, sw_rise, sw_fall);
            end
        end
    endtask

    // Raw change is driven just after an edge; the next edge is E0 and sw_clean must move at E9.
    task automatic test_single_rise();
        logic [3:0] exp_clean, exp_rise;
        sw_raw = 4'b0001;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b0001 : 4'b0000;
            exp_rise  = (k == 9) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== exp_rise || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL single_rise E%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=0000",
                         k, sw_clean, sw_rise, sw_fall, exp_clean, exp_rise);
            end
        end
    endtask

    task automatic test_glitch_reject();
        logic [3:0] exp_clean, exp_rise;
        sw_raw = 4'b0011;
        repeat (7) @(posedge clk);
        #1;
        sw_raw = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (sw_clean !== 4'b0001 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL glitch_7 k=%0d: got clean=%b rise=%b fall=%b, want clean=0001 rise=0000 fall=0000",
                         k, sw_clean, sw_rise, sw_fall);
            end
        end
        sw_raw = 4'b0011;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b0011 : 4'b0001;
            exp_rise  = (k == 9) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== exp_rise || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL glitch_accept E%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=0000",
                         k, sw_clean, sw_rise, sw_fall, exp_clean, exp_rise);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        logic [3:0] exp_clean, exp_rise;
        seq = 5'b01101;
        for (int s = 0; s < 5; s++) begin
            sw_raw = {1'b0, seq[s], 2'b11};
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                n_cmp++;
                if (sw_clean !== 4'b0011 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000) begin
                    n_err++;
                    $display("FAIL bounce s=%0d c=%0d: got clean=%b rise=%b fall=%b, want clean=0011 rise=0000 fall=0000",
                             s, c, sw_clean, sw_rise, sw_fall);
                end
            end
        end
        sw_raw = 4'b0111;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b0111 : 4'b0011;
            exp_rise  = (k == 9) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== exp_rise || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL bounce_settle E%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=0000",
                         k, sw_clean, sw_rise, sw_fall, exp_clean, exp_rise);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_clean, exp_rise, exp_fall;
        sw_raw = 4'b0000;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b0000 : 4'b0111;
            exp_fall  = (k == 9) ? 4'b0111 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== 4'b0000 || sw_fall !== exp_fall) begin
                n_err++;
                $display("FAIL all_low E%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=0000 fall=%b",
                         k, sw_clean, sw_rise, sw_fall, exp_clean, exp_fall);
            end
        end
        sw_raw = 4'b1111;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b1111 : 4'b0000;
            exp_rise  = (k == 9) ? 4'b1111 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== exp_rise || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL all_rise E%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=0000",
                         k, sw_clean, sw_rise, sw_fall, exp_clean, exp_rise);
            end
        end
        sw_raw = 4'b0101;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b0101 : 4'b1111;
            exp_fall  = (k == 9) ? 4'b1010 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== 4'b0000 || sw_fall !== exp_fall) begin
                n_err++;
                $display("FAIL mixed_fall E%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=0000 fall=%b",
                         k, sw_clean, sw_rise, sw_fall, exp_clean, exp_fall);
            end
        end
    endtask

    // Bit 3 counter has reached 5 after E6 when reset is pulled; the count must be discarded.
    task automatic test_reset_mid_count();
        logic [3:0] exp_clean, exp_rise;
        sw_raw = 4'b1000;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (sw_clean !== 4'b0101 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL pre_reset E%0d: got clean=%b rise=%b fall=%b, want clean=0101 rise=0000 fall=0000",
                         k, sw_clean, sw_rise, sw_fall);
            end
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({sw_clean, sw_rise, sw_fall} !== 12'h000) begin
            n_err++;
            $display("FAIL async_reset: got clean=%b rise=%b fall=%b, want all 0", sw_clean, sw_rise, sw_fall);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({sw_clean, sw_rise, sw_fall} !== 12'h000) begin
                n_err++;
                $display("FAIL in_reset k=%0d: got clean=%b rise=%b fall=%b, want all 0", k, sw_clean, sw_rise, sw_fall);
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 9) ? 4'b1000 : 4'b0000;
            exp_rise  = (k == 9) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (sw_clean !== exp_clean || sw_rise !== exp_rise || sw_fall !== 4'b0000) begin
                n_err++;
                $display("FAIL post_reset edge%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=0000",
                         k + 1, sw_clean, sw_rise, sw_fall, exp_clean, exp_rise);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        sw_raw  = 4'b0000;
        test_reset();
        test_single_rise();
        test_glitch_reject();
        test_bounce();
        test_back_to_back();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
